// File: rtl/multicycle_state_sequencer.sv
// Control-state sequencer for the multicycle RV32I core: walks each instruction
// through IF/ID/EX_1/EX_2/MEM/WB, traps illegal opcodes, and keeps cycle/retire counters.
module multicycle_state_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             bcond,
    input  logic             halt_req,
    output logic [2:0]       current_state,
    output logic             is_halted,
    output logic             illegal_inst,
    output logic             inst_done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_IF     = 3'd0,
        S_ID     = 3'd1,
        S_EX1    = 3'd2,
        S_EX2    = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_UNUSED = 3'd7
    } state_t;

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] cycle_q, retired_q;
    logic             trap;
    logic             is_alu, is_mem, legal;

    always_comb begin
        is_alu = (opcode == OP_ARITH) || (opcode == OP_ARITH_IMM) ||
                 (opcode == OP_JAL)   || (opcode == OP_JALR);
        is_mem = (opcode == OP_LOAD)  || (opcode == OP_STORE);
        legal  = is_alu || is_mem || (opcode == OP_BRANCH) || (opcode == OP_ECALL);
    end

    always_comb begin
        state_d = S_IF;
        trap    = 1'b0;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (opcode == OP_ECALL) begin
                    state_d = halt_req ? S_HALT : S_IF;
                end else if (!legal) begin
                    state_d = S_HALT;
                    trap    = 1'b1;
                end else begin
                    state_d = S_EX1;
                end
            end
            S_EX1: begin
                if (is_alu)                   state_d = S_WB;
                else if (is_mem)              state_d = S_MEM;
                else if (opcode == OP_BRANCH) state_d = bcond ? S_EX2 : S_IF;
                else                          state_d = S_IF;
            end
            S_EX2:  state_d = S_IF;
            S_MEM:  state_d = (opcode == OP_LOAD) ? S_WB : S_IF;
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Retirement is the last cycle of an instruction; the illegal trap retires nothing.
    always_comb begin
        inst_done = !reset && !trap &&
                    (state_q != S_HALT) && (state_q != S_UNUSED) &&
                    ((state_d == S_IF) || (state_d == S_HALT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IF;
            illegal_q <= 1'b0;
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (trap)
                illegal_q <= 1'b1;
            if (state_q != S_HALT)
                cycle_q <= cycle_q + CNT_ONE;
            if (inst_done)
                retired_q <= retired_q + CNT_ONE;
        end
    end

    assign current_state = state_q;
    assign is_halted     = (state_q == S_HALT);
    assign illegal_inst  = illegal_q;
    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_multicycle_state_sequencer.sv
// Scoreboarded bench: directed instruction sequences with hand-written per-cycle
// state tables; a negedge monitor checks a 32-bit and a 4-bit counter instance.
module tb_multicycle_state_sequencer;

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;
    localparam logic [6:0] OP_BAD       = 7'b1111111;

    localparam logic [2:0] IF = 3'd0, ID = 3'd1, EX1 = 3'd2, EX2 = 3'd3,
                           MEM = 3'd4, WB = 3'd5, HLT = 3'd6;

    typedef struct {
        logic [2:0]  st;
        logic        dn;
        logic        hl;
        logic        il;
        logic [31:0] cy;
        logic [31:0] rt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        bcond = 1'b0;
    logic        halt_req = 1'b0;

    logic [2:0]  st_a, st_b;
    logic        hl_a, il_a, dn_a, hl_b, il_b, dn_b;
    logic [31:0] cy_a, rt_a;
    logic [3:0]  cy_b, rt_b;

    exp_t        q[$];
    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] exp_cyc = 0;
    logic [31:0] exp_ret = 0;
    logic        exp_ill = 1'b0;

    always #5 clk = ~clk;

    multicycle_state_sequencer #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_req(halt_req),
        .current_state(st_a), .is_halted(hl_a), .illegal_inst(il_a), .inst_done(dn_a),
        .cycle_count(cy_a), .retired_count(rt_a)
    );

    multicycle_state_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_req(halt_req),
        .current_state(st_b), .is_halted(hl_b), .illegal_inst(il_b), .inst_done(dn_b),
        .cycle_count(cy_b), .retired_count(rt_b)
    );

    // Monitor: one expected record per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            nvec++;
            if (st_a !== e.st || dn_a !== e.dn || hl_a !== e.hl || il_a !== e.il ||
                cy_a !== e.cy || rt_a !== e.rt) begin
                nerr++;
                $display("FAIL cyc32 @%0t: got st=%0d done=%0b halt=%0b ill=%0b cyc=%0d ret=%0d, want st=%0d done=%0b halt=%0b ill=%0b cyc=%0d ret=%0d",
                         $time, st_a, dn_a, hl_a, il_a, cy_a, rt_a,
                         e.st, e.dn, e.hl, e.il, e.cy, e.rt);
            end
            nvec++;
            if (st_b !== e.st || dn_b !== e.dn || cy_b !== e.cy[3:0] || rt_b !== e.rt[3:0]) begin
                nerr++;
                $display("FAIL cnt4 @%0t: got st=%0d done=%0b cyc=%0d ret=%0d, want st=%0d done=%0b cyc=%0d ret=%0d",
                         $time, st_b, dn_b, cy_b, rt_b, e.st, e.dn, e.cy[3:0], e.rt[3:0]);
            end
        end
    end

    task automatic apply(input logic [6:0] op, input logic bc, input logic hr,
                         input logic [2:0] st, input logic dn);
        exp_t e;
        opcode   = op;
        bcond    = bc;
        halt_req = hr;
        e.st = st; e.dn = dn; e.hl = (st == HLT); e.il = exp_ill;
        e.cy = exp_cyc; e.rt = exp_ret;
        q.push_back(e);
        @(posedge clk);
        if (st != HLT) exp_cyc = exp_cyc + 1;
        if (dn)        exp_ret = exp_ret + 1;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        exp_cyc = 0; exp_ret = 0; exp_ill = 1'b0;
        #1 reset = 1'b0;
    endtask

    task automatic four_cycle(input logic [6:0] op);
        apply(op, 1'b0, 1'b0, IF,  1'b0);
        apply(op, 1'b1, 1'b1, ID,  1'b0);
        apply(op, 1'b0, 1'b0, EX1, 1'b0);
        apply(op, 1'b1, 1'b0, WB,  1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] rop;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        four_cycle(OP_ARITH);
        // LOAD then STORE back-to-back
        apply(OP_LOAD,  1'b0, 1'b0, IF,  1'b0);
        apply(OP_LOAD,  1'b0, 1'b0, ID,  1'b0);
        apply(OP_LOAD,  1'b0, 1'b0, EX1, 1'b0);
        apply(OP_LOAD,  1'b0, 1'b0, MEM, 1'b0);
        apply(OP_LOAD,  1'b0, 1'b0, WB,  1'b1);
        apply(OP_STORE, 1'b0, 1'b0, IF,  1'b0);
        apply(OP_STORE, 1'b0, 1'b0, ID,  1'b0);
        apply(OP_STORE, 1'b0, 1'b0, EX1, 1'b0);
        apply(OP_STORE, 1'b0, 1'b0, MEM, 1'b1);
        // Branches, bcond driven opposite outside EX_1
        apply(OP_BRANCH, 1'b0, 1'b0, IF,  1'b0);
        apply(OP_BRANCH, 1'b0, 1'b0, ID,  1'b0);
        apply(OP_BRANCH, 1'b1, 1'b0, EX1, 1'b0);
        apply(OP_BRANCH, 1'b0, 1'b0, EX2, 1'b1);
        apply(OP_BRANCH, 1'b1, 1'b0, IF,  1'b0);
        apply(OP_BRANCH, 1'b1, 1'b0, ID,  1'b0);
        apply(OP_BRANCH, 1'b0, 1'b0, EX1, 1'b1);
        // Non-halting ECALL, halt_req raised only outside ID
        apply(OP_ECALL, 1'b0, 1'b1, IF, 1'b0);
        apply(OP_ECALL, 1'b0, 1'b0, ID, 1'b1);
        four_cycle(OP_JAL);
        // Halting ECALL: retires once, then counters freeze
        apply(OP_ECALL, 1'b0, 1'b0, IF, 1'b0);
        apply(OP_ECALL, 1'b0, 1'b1, ID, 1'b1);
        for (int i = 0; i < 20; i++) begin
            rop = 7'($urandom);
            apply(rop, 1'($urandom), 1'($urandom), HLT, 1'b0);
        end

        do_reset();
        apply(OP_BAD, 1'b0, 1'b0, IF, 1'b0);
        apply(OP_BAD, 1'b0, 1'b1, ID, 1'b0);
        exp_ill = 1'b1;
        for (int i = 0; i < 3; i++)
            apply(OP_ARITH, 1'b1, 1'b1, HLT, 1'b0);

        do_reset();
        // 16 four-cycle instructions wrap both 4-bit counters
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: four_cycle(OP_ARITH);
                1: four_cycle(OP_ARITH_IMM);
                2: four_cycle(OP_JAL);
                default: four_cycle(OP_JALR);
            endcase
        end

        // Reset asserted mid-instruction in EX_1
        apply(OP_LOAD, 1'b0, 1'b0, IF, 1'b0);
        apply(OP_LOAD, 1'b0, 1'b0, ID, 1'b0);
        reset = 1'b1;
        apply(OP_LOAD, 1'b0, 1'b0, EX1, 1'b0);
        exp_cyc = 0; exp_ret = 0; exp_ill = 1'b0;
        reset = 1'b0;
        four_cycle(OP_ARITH);
        apply(OP_ARITH, 1'b0, 1'b0, IF, 1'b0);

        repeat (2) @(negedge clk);
        nvec++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL drain: got %0d pending records, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
